// File: rtl/sfx_sequencer_pkg.sv
// Shared types and constants for the sound-effect sequencer and its melody ROM.
package sfx_sequencer_pkg;

  localparam int ROM_DIV_W  = 20;
  localparam int IDX_W      = 4;
  localparam int ROM_ADDR_W = 2 + IDX_W;

  // Song identifiers; a larger value means a higher arbitration priority.
  typedef enum logic [1:0] {
    SONG_DROP = 2'd0,
    SONG_DRAW = 2'd1,
    SONG_WIN  = 2'd2,
    SONG_NONE = 2'd3
  } song_e;

  // Note divisors for a 100 MHz clock: f = f_clk / (2 * (div + 1)).
  localparam logic [ROM_DIV_W-1:0] DIV_C5   = 20'd95555;
  localparam logic [ROM_DIV_W-1:0] DIV_E5   = 20'd75842;
  localparam logic [ROM_DIV_W-1:0] DIV_G5   = 20'd63775;
  localparam logic [ROM_DIV_W-1:0] DIV_C6   = 20'd47777;
  localparam logic [ROM_DIV_W-1:0] DIV_REST = 20'd0;

  // One melody step: divisor, length in beats, and end-of-song marker.
  typedef struct packed {
    logic [ROM_DIV_W-1:0] div;
    logic [3:0]           len;
    logic                 last;
  } rom_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  function automatic rom_entry_t mk_entry(input logic [ROM_DIV_W-1:0] div,
                                          input logic [3:0]           len,
                                          input logic                 last);
    rom_entry_t e;
    e.div  = div;
    e.len  = len;
    e.last = last;
    return e;
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Melody ROM: 4 songs x 16 steps, addressed by {song, idx}, one-cycle registered read.
module sfx_rom
  import sfx_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROM_ADDR_W-1:0] addr_i,
  output rom_entry_t            data_o
);

  rom_entry_t word_d;
  rom_entry_t word_q;

  // Constant melody table; unlisted addresses (including song 3) read as a final rest.
  always_comb begin
    // NOTE: every path of a combinational block assigns its outputs (default first), so no latch is inferred.
    word_d = mk_entry(DIV_REST, 4'd1, 1'b1);
    case (addr_i)
      {SONG_DROP, 4'd0}: word_d = mk_entry(DIV_G5,   4'd1, 1'b0);
      {SONG_DROP, 4'd1}: word_d = mk_entry(DIV_C6,   4'd1, 1'b1);
      {SONG_DRAW, 4'd0}: word_d = mk_entry(DIV_G5,   4'd2, 1'b0);
      {SONG_DRAW, 4'd1}: word_d = mk_entry(DIV_E5,   4'd2, 1'b0);
      {SONG_DRAW, 4'd2}: word_d = mk_entry(DIV_C5,   4'd4, 1'b1);
      {SONG_WIN,  4'd0}: word_d = mk_entry(DIV_C5,   4'd1, 1'b0);
      {SONG_WIN,  4'd1}: word_d = mk_entry(DIV_E5,   4'd1, 1'b0);
      {SONG_WIN,  4'd2}: word_d = mk_entry(DIV_G5,   4'd1, 1'b0);
      {SONG_WIN,  4'd3}: word_d = mk_entry(DIV_C6,   4'd2, 1'b0);
      {SONG_WIN,  4'd4}: word_d = mk_entry(DIV_REST, 4'd1, 1'b0);
      {SONG_WIN,  4'd5}: word_d = mk_entry(DIV_C6,   4'd4, 1'b1);
      default:           word_d = mk_entry(DIV_REST, 4'd1, 1'b1);
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only the read register is reset; the table itself is constant logic, not storage.
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign data_o = word_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates game-event requests and steps a melody from
// the ROM, driving the note generator divisor and the codec mute flag.
module sfx_sequencer
  import sfx_sequencer_pkg::*;
#(
  parameter int BEAT_CYCLES = 5_000_000,
  parameter int DIV_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_drop,
  input  logic             req_draw,
  input  logic             req_win,
  output logic [DIV_W-1:0] note_div,
  output logic             mute,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = '1;

  state_e             state_q,    state_d;
  song_e              song_q,     song_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [3:0]         beats_q,    beats_d;
  logic [DIV_W-1:0]   note_div_q, note_div_d;
  logic               mute_q,     mute_d;
  logic               done_q,     done_d;

  logic               req_valid;
  song_e              req_song;
  logic               preempt;
  rom_entry_t         rom_entry;

  // Fixed-priority request decode: win > draw > drop.
  always_comb begin
    req_valid = req_win | req_draw | req_drop;
    req_song  = SONG_DROP;
    if (req_win)       req_song = SONG_WIN;
    else if (req_draw) req_song = SONG_DRAW;
    preempt = req_valid && (req_song > song_q);
  end

  // The ROM is addressed with the next song/index so its data is ready during LOAD.
  sfx_rom u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i ({song_d, idx_d}),
    .data_o (rom_entry)
  );

  // Next-state logic: arbitration, note loading and beat timing.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    beats_d    = beats_q;
    note_div_d = note_div_q;
    mute_d     = mute_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          song_d  = req_song;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (preempt) begin
          // Restart on the new song; outputs keep the old note meanwhile.
          song_d = req_song;
          idx_d  = '0;
        end else begin
          if (rom_entry.div == DIV_REST) begin
            note_div_d = '0;
            mute_d     = 1'b1;
          end else begin
            note_div_d = DIV_W'(rom_entry.div);
            mute_d     = 1'b0;
          end
          beat_cnt_d = '0;
          beats_d    = (rom_entry.len == 4'd0) ? 4'd1 : rom_entry.len;
          state_d    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (preempt) begin
          song_d  = req_song;
          idx_d   = '0;
          state_d = ST_LOAD;
        end else if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d = '0;
          if (beats_q <= 4'd1) begin
            if (rom_entry.last || (idx_q == IDX_LAST)) begin
              note_div_d = '0;
              mute_d     = 1'b1;
              done_d     = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            beats_d = beats_q - 4'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      song_q     <= SONG_DROP;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      beats_q    <= '0;
      note_div_q <= '0;
      mute_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      beats_q    <= beats_d;
      note_div_q <= note_div_d;
      mute_q     <= mute_d;
      done_q     <= done_d;
    end
  end

  assign note_div = note_div_q;
  assign mute     = mute_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with BEAT_CYCLES = 4.
module tb_sfx_sequencer;

  localparam int DIV_W = 20;

  logic             clk;
  logic             rst_n;
  logic             req_drop;
  logic             req_draw;
  logic             req_win;
  logic [DIV_W-1:0] note_div;
  logic             mute;
  logic             busy;
  logic             done;

  int n_tests;
  int n_fail;

  // Expected win melody as seen on the outputs: divisor and visible cycles per step.
  int win_div [6] = '{95555, 75842, 63775, 47777, 0, 47777};
  int win_cyc [6] = '{5, 5, 5, 9, 5, 16};

  sfx_sequencer #(
    .BEAT_CYCLES (4),
    .DIV_W       (DIV_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_drop (req_drop),
    .req_draw (req_draw),
    .req_win  (req_win),
    .note_div (note_div),
    .mute     (mute),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs steady on one note for n cycles while a song is in progress.
  task automatic seg(input string tag, input int div, input bit mu, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_div"},  int'(note_div), div);
      check({tag, "_mute"}, int'(mute),     int'(mu));
      check({tag, "_busy"}, int'(busy),     1);
      check({tag, "_done"}, int'(done),     0);
      step();
    end
  endtask

  // Completion cycle followed by the cycle after it.
  task automatic check_done(input string tag);
    check({tag, "_end_div"},  int'(note_div), 0);
    check({tag, "_end_mute"}, int'(mute),     1);
    check({tag, "_end_busy"}, int'(busy),     0);
    check({tag, "_end_done"}, int'(done),     1);
    step();
    check({tag, "_post_done"}, int'(done), 0);
  endtask

  task automatic play_win(input string tag, input bit release_draw);
    for (int s = 0; s < 6; s++) begin
      if (release_draw && s == 2) req_draw = 1'b0;
      seg($sformatf("%s_n%0d", tag, s), win_div[s], (win_div[s] == 0), win_cyc[s]);
    end
    check_done(tag);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_div"},  int'(note_div), 0);
    check({tag, "_mute"}, int'(mute),     1);
    check({tag, "_busy"}, int'(busy),     0);
    check({tag, "_done"}, int'(done),     0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req_drop = 1'b1;
    req_draw = 1'b1;
    req_win  = 1'b1;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst_hold");
    end
    req_drop = 1'b0;
    req_draw = 1'b0;
    req_win  = 1'b0;
    rst_n    = 1'b1;
    step();
    check_idle("post_rst");
    step();

    // Drop pulse: G5 for 5 cycles, C6 for 4, then done.
    req_drop = 1'b1;
    check("drop_t0_busy", int'(busy), 0);
    step();
    req_drop = 1'b0;
    check("drop_load_busy", int'(busy), 1);
    check("drop_load_mute", int'(mute), 1);
    check("drop_load_div",  int'(note_div), 0);
    step();
    seg("drop_g5", 63775, 1'b0, 5);
    seg("drop_c6", 47777, 1'b0, 4);
    check_done("drop");
    check("drop_after_busy", int'(busy), 0);
    step();

    // Win pulse: full melody including a rest.
    req_win = 1'b1;
    step();
    req_win = 1'b0;
    check("win_load_busy", int'(busy), 1);
    check("win_load_div",  int'(note_div), 0);
    step();
    play_win("win", 1'b0);
    step();

    // Draw preempted by win during the E5 note.
    req_draw = 1'b1;
    step();
    req_draw = 1'b0;
    check("draw_load_busy", int'(busy), 1);
    step();
    seg("draw_g5", 63775, 1'b0, 9);
    seg("draw_e5", 75842, 1'b0, 2);
    check("draw_e5_pre_div", int'(note_div), 75842);
    req_win = 1'b1;
    step();
    req_win = 1'b0;
    check("preempt_hold_div",  int'(note_div), 75842);
    check("preempt_hold_busy", int'(busy), 1);
    check("preempt_no_done",   int'(done), 0);
    step();
    play_win("win_pre", 1'b0);
    step();

    // Win with lower-priority requests present; drop held through done.
    req_win  = 1'b1;
    req_draw = 1'b1;
    req_drop = 1'b1;
    step();
    req_win = 1'b0;
    check("prio_load_busy", int'(busy), 1);
    step();
    play_win("win_ign", 1'b1);
    check("drop_restart_busy", int'(busy), 1);
    check("drop_restart_div",  int'(note_div), 0);
    check("drop_restart_mute", int'(mute), 1);
    req_drop = 1'b0;
    step();
    seg("drop2_g5", 63775, 1'b0, 5);
    seg("drop2_c6", 47777, 1'b0, 4);
    check_done("drop2");
    step();

    // Reset mid-song: outputs clear without a clock edge.
    req_drop = 1'b1;
    step();
    req_drop = 1'b0;
    step();
    step();
    check("midrst_pre_div", int'(note_div), 63775);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midrst_async");
    step();
    check_idle("midrst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("midrst_idle");
    end

    // Fresh request after reset plays normally.
    req_drop = 1'b1;
    step();
    req_drop = 1'b0;
    step();
    seg("drop3_g5", 63775, 1'b0, 5);
    seg("drop3_c6", 47777, 1'b0, 4);
    check_done("drop3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Sound-effect scheduler that drives the note_div input of the square-wave note generator.
- Arbitrates between three game-event requesters: piece drop, win and draw.
- Plays the selected short melody from an internal ROM by stepping through note divisors, each held for a programmable number of beats.
- Sits between the game-control FSM and the audio note generator. It also supplies a mute flag so the audio mux can silence the codec between effects.

Parameters:
- BEAT_CYCLES, 5_000_000, clk cycles per beat (50 ms at 100 MHz); the bench overrides it to 4.
- DIV_W, 20, width of note divisor.

Ports:
- clk  in  1  crystal clock.
- rst_n  in  1  asynchronous active-low reset.
- req_drop  in  1  level request, drop effect (song 0).
- req_draw  in  1  level request, draw effect (song 1).
- req_win  in  1  level request, win effect (song 2).
- note_div  out  DIV_W  divisor to the note generator; tone freq = f_clk / (2*(note_div+1)).
- mute  out  1  1 = audio must be silenced (idle or rest note).
- busy  out  1  1 while a song is in progress.
- done  out  1  one-cycle pulse when a song completes normally.

Behaviour:
- Reset (async, rst_n low): state IDLE, note_div=0, mute=1, busy=0, done=0, all counters 0.
- Priority: win > draw > drop. Requests are sampled every clk; there is no request latching.
- FSM states are IDLE, LOAD and PLAY.
- IDLE:
  - Any request selects the highest-priority song, sets idx=0, and goes to LOAD next cycle.
  - busy rises in the same cycle as the LOAD entry.
- LOAD (exactly 1 cycle): the registered ROM read of {song, idx} completes.
  - At the end of LOAD, note_div and mute are updated from the entry: mute=1 and note_div=0 if entry div==0 (rest), else mute=0.
  - Beat counter and beat-remaining counter are loaded (len==0 is treated as 1).
  - Next state is PLAY.
- PLAY:
  - The beat counter counts BEAT_CYCLES cycles per beat.
  - When the last beat expires:
    - If entry.last is set or idx==15, go to IDLE. In that cycle: note_div=0, mute=1, busy=0, done=1 for one cycle.
    - Otherwise idx=idx+1 and go to LOAD. Outputs hold during LOAD.
- Note visibility:
  - Each non-final note is visible for len*BEAT_CYCLES+1 cycles; the final note is visible for len*BEAT_CYCLES cycles.
  - Latency from request (IDLE) to first note on outputs is 2 cycles.
- Preemption:
  - A request of strictly higher priority than the current song, seen in LOAD or PLAY, aborts the current song and restarts at idx=0 of the new song via LOAD.
  - Outputs hold until the new LOAD completes; no done pulse for the aborted song.
  - Equal or lower priority requests are ignored while busy.
- Simultaneous completion and request: the done cycle goes to IDLE. A request still asserted is accepted on the following IDLE cycle, which keeps done single-cycle.
- Index wrap: idx never exceeds 15; idx==15 is forced last.
- Reset mid-song: immediate return to reset values; no done pulse.
- Beat counter width: ceil(log2(BEAT_CYCLES)). Beat-remaining counter: 4 bits.
- ROM contents at 100 MHz, as div/len:
  - Song 0 (drop): G5 63775/1, C6 47777/1 last.
  - Song 1 (draw): G5 63775/2, E5 75842/2, C5 95555/4 last.
  - Song 2 (win): C5 95555/1, E5 75842/1, G5 63775/1, C6 47777/2, rest 0/1, C6 47777/4 last.
  - Song 3: unused. Entry 0 of song 3 is a rest with last=1.

Decomposition:
- Shared package holds:
  - Song IDs: SONG_DROP=0, SONG_DRAW=1, SONG_WIN=2.
  - Note divisor constants: C5, E5, G5, C6, REST=0.
  - ROM entry layout: div[19:0], len[3:0], last.
  - FSM state encoding.
- Sub-module sfx_rom: synchronous 64-entry ROM, address {song[1:0], idx[3:0]}, 1-cycle registered read, 25-bit output. The sequencer contains only the FSM, arbitration and counters.

Test Plan (BEAT_CYCLES=4):
- Reset held with requests active -> note_div=0, mute=1, busy=0, done=0; no state change until rst_n rises.
- req_drop 1-cycle pulse at t0 -> at t0+2, note_div=63775, mute=0 for 5 cycles; then 47777 for 4 cycles; then note_div=0, mute=1, done=1 exactly once; busy high for 10 cycles total.
- req_win pulse -> divisors 95555, 75842, 63775, 47777, rest, 47777. Rest interval shows mute=1, note_div=0 for 5 cycles; final C6 holds 16 cycles; done pulse at end.
- req_draw playing, req_win asserted during the E5 note -> within 2 cycles note_div=95555 (win idx 0); no done for draw; win completes with a single done.
- req_win playing, req_drop and req_draw asserted -> ignored; win sequence unchanged. req_drop held high through done -> drop starts 1 cycle after the done cycle.
- rst_n pulsed low mid-song -> outputs return asynchronously to reset values; no done. After release, idle until a new request.
